i_ram_loader: RTL and testbench
===============================

// Module: i_ram_loader
// PURPOSE
//  UART boot loader sitting directly upstream of the instruction RAM write port.
//  - Consumes received bytes and parses the frame: sync 0xA5, word count, payload, optional checksum.
//  - Packs byte pairs little-endian into 16-bit words and writes them to consecutive RAM addresses from 0.
//  - Holds the CPU in reset until a load completes successfully.
// PARAMETERS
//  ADDR_WIDTH  12      instruction RAM address width; depth = 1<<ADDR_WIDTH words
//  DATA_WIDTH  16      instruction word width; fixed at 16 (two bytes per word)
//  TIMEOUT     100000  max idle clk cycles between bytes inside a frame before error
// PORTS
//  clk         in   1           system clock
//  rst         in   1           synchronous, active-high reset
//  ld_en       in   1           1 = sync byte may (re)start a load; 0 = bytes ignored in IDLE/RUN
//  rx_data     in   8           received UART byte
//  rx_valid    in   1           one-cycle strobe, rx_data valid
//  ram_w_addr  out  ADDR_WIDTH  RAM write address
//  ram_din     out  DATA_WIDTH  RAM write data
//  ram_w_en    out  1           RAM write enable, one-cycle pulse per word
//  cpu_rst     out  1           CPU reset; 1 in every state except RUN
//  busy        out  1           1 while in LEN_LO..CHK
//  done        out  1           one-cycle pulse on entry to RUN
//  err         out  1           1 while in ERR
// BEHAVIOUR
//  Reset:
//  - state=IDLE; cpu_rst=1; all other outputs 0.
//  - Internal counters and checksum cleared.
//  States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, RUN, ERR.
//  State transitions (each byte below is a rx_valid strobe):
//  - IDLE/RUN/ERR: byte==0xA5 with ld_en=1 -> LEN_LO.
//    Other bytes ignored. Entering LEN_LO sets cpu_rst=1 and clears err.
//  - LEN_LO: latch len[7:0] -> LEN_HI.
//  - LEN_HI: latch len[15:8].
//    len==0 -> CHK (macro on) or RUN (macro off).
//    len > 1<<ADDR_WIDTH -> ERR.
//    Otherwise -> DATA_LO with addr=0.
//  - DATA_LO: latch lo byte -> DATA_HI.
//  - DATA_HI: register ram_din={byte,lo}, ram_w_addr=addr, ram_w_en=1 for the next cycle only.
//    Then addr+=1 and remaining count -= 1.
//    Last word -> CHK (macro on) or RUN (macro off); else -> DATA_LO.
//  Write latency: 1 clk from the DATA_HI strobe to the ram_w_en pulse.
//  ram_w_addr/ram_din hold their last values when ram_w_en=0.
//  Timeout:
//  - Idle counter clears on every rx_valid and counts in LEN_LO..CHK.
//  - Reaching TIMEOUT -> ERR.
//  - Counter is inactive in IDLE/RUN/ERR.
//  Simultaneous events:
//  - rst has priority over everything.
//  - A byte arriving on the same cycle as timeout expiry is consumed; no ERR.
//  - A 0xA5 byte mid-frame is data, not a resync.
//  Reset mid-frame: load aborts; RAM contents already written are left as-is; cpu_rst=1.
//  done pulses only on a transition into RUN. err and cpu_rst are level outputs.
//  At most 1<<ADDR_WIDTH writes; the address never wraps.
// CONFIGURATION
//  I_RAM_LOADER_CHECKSUM_EN defined:
//  - 8-bit running sum (mod 256) of all payload bytes.
//  - CHK waits for one byte: equal to sum -> RUN; unequal -> ERR.
//  I_RAM_LOADER_CHECKSUM_EN undefined:
//  - CHK state and sum logic are absent; the frame ends after the last data byte.
// TESTING
//  1. rst 2 cycles -> cpu_rst=1, ram_w_en=0, done=0, err=0, busy=0.
//  2. Frame A5,02,00,34,12,78,56 (+ checksum 0x14 if macro) -> writes [0]=0x1234, [1]=0x5678;
//     done pulses once; cpu_rst=0.
//  3. Frame A5,01,00,CD,AB + checksum 0x00 (macro on) -> err=1, cpu_rst=1, no done;
//     then A5,00,00,00 -> done, cpu_rst=0.
//  4. Frame A5,01,10 with ADDR_WIDTH=12 (len 0x1001 > 4096) -> ERR; no ram_w_en pulse.
//  5. A5,01,00,11 then silence for TIMEOUT cycles -> err=1.
//     Repeat with a byte landing exactly at expiry -> no error.
//  6. In RUN, ld_en=0 with byte 0xA5 -> ignored, cpu_rst stays 0;
//     ld_en=1 with 0xA5 -> cpu_rst=1, busy=1.

Source files
------------

// File: rtl/i_ram_loader.sv
// i_ram_loader: UART boot loader that parses A5/len/payload frames into 16-bit RAM writes.
// Define I_RAM_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module i_ram_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_en,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_w_en,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [16:0]   MAX_LEN = 17'(1 << ADDR_WIDTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHK, S_RUN, S_ERR
  } state_t;

`ifdef I_RAM_LOADER_CHECKSUM_EN
  localparam state_t S_FRAME_END = S_CHK;
`else
  localparam state_t S_FRAME_END = S_RUN;
`endif

  state_t                r_state, w_state_next;
  logic [7:0]            r_len_lo, w_len_lo_next;
  logic [7:0]            r_lo, w_lo_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [CW-1:0]         r_remain, w_remain_next;
  logic [TW-1:0]         r_idle_cnt;
  logic [ADDR_WIDTH-1:0] r_ram_w_addr, w_wr_addr_next;
  logic [DATA_WIDTH-1:0] r_ram_din, w_din_next;
  logic                  r_ram_w_en, w_wr_en_next;
  logic                  r_done;
  logic [15:0]           w_len;
  logic                  w_busy;
  logic                  w_timeout;
`ifdef I_RAM_LOADER_CHECKSUM_EN
  logic [7:0]            r_sum, w_sum_next;
`endif

  assign w_len  = {rx_data, r_len_lo};
  assign w_busy = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA_LO) ||
                  (r_state == S_DATA_HI) || (r_state == S_CHK);
  // A byte on the expiry cycle wins: expiry only fires on a cycle with no strobe.
  assign w_timeout = w_busy && !rx_valid && (r_idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_len_lo_next  = r_len_lo;
    w_lo_next      = r_lo;
    w_addr_next    = r_addr;
    w_remain_next  = r_remain;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = r_ram_w_addr;
    w_din_next     = r_ram_din;
`ifdef I_RAM_LOADER_CHECKSUM_EN
    w_sum_next     = r_sum;
`endif
    case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (rx_valid && ld_en && (rx_data == 8'hA5)) begin
          w_state_next = S_LEN_LO;
`ifdef I_RAM_LOADER_CHECKSUM_EN
          w_sum_next   = 8'h00;
`endif
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          w_len_lo_next = rx_data;
          w_state_next  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (w_len == 16'h0000) begin
            w_state_next = S_FRAME_END;
          end else if ({1'b0, w_len} > MAX_LEN) begin
            w_state_next = S_ERR;
          end else begin
            w_addr_next   = '0;
            w_remain_next = CW'(w_len);
            w_state_next  = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (rx_valid) begin
          w_lo_next    = rx_data;
          w_state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (rx_valid) begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = r_addr;
          w_din_next     = DATA_WIDTH'({rx_data, r_lo});
          w_addr_next    = r_addr + ADDR_WIDTH'(1);
          w_remain_next  = r_remain - CW'(1);
`ifdef I_RAM_LOADER_CHECKSUM_EN
          w_sum_next     = r_sum + r_lo + rx_data;
`endif
          w_state_next   = (r_remain == CW'(1)) ? S_FRAME_END : S_DATA_LO;
        end
      end
`ifdef I_RAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) w_state_next = (rx_data == r_sum) ? S_RUN : S_ERR;
      end
`endif
      default: ;
    endcase
    if (w_timeout) w_state_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_lo     <= '0;
      r_lo         <= '0;
      r_addr       <= '0;
      r_remain     <= '0;
      r_idle_cnt   <= '0;
      r_ram_w_addr <= '0;
      r_ram_din    <= '0;
      r_ram_w_en   <= 1'b0;
      r_done       <= 1'b0;
`ifdef I_RAM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_len_lo     <= w_len_lo_next;
      r_lo         <= w_lo_next;
      r_addr       <= w_addr_next;
      r_remain     <= w_remain_next;
      r_idle_cnt   <= (!w_busy || rx_valid) ? '0 : r_idle_cnt + TW'(1);
      r_ram_w_addr <= w_wr_addr_next;
      r_ram_din    <= w_din_next;
      r_ram_w_en   <= w_wr_en_next;
      r_done       <= (w_state_next == S_RUN) && (r_state != S_RUN);
`ifdef I_RAM_LOADER_CHECKSUM_EN
      r_sum        <= w_sum_next;
`endif
    end
  end

  assign ram_w_addr = r_ram_w_addr;
  assign ram_din    = r_ram_din;
  assign ram_w_en   = r_ram_w_en;
  assign done       = r_done;
  assign cpu_rst    = (r_state != S_RUN);
  assign busy       = w_busy;
  assign err        = (r_state == S_ERR);
endmodule

// File: tb/tb_i_ram_loader.sv
// Randomized self-checking bench for i_ram_loader; frame outcomes come from a byte-level parse model.
`timescale 1ns/1ps
module tb_i_ram_loader;
  localparam int AW    = 12;
  localparam int TO    = 20;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, ld_en, rx_valid;
  logic [7:0]    rx_data;
  logic [AW-1:0] ram_w_addr;
  logic [15:0]   ram_din;
  logic          ram_w_en, cpu_rst, busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [AW-1:0] got_addr[$];
  logic [15:0]   got_data[$];
  logic [15:0]   exp_data[$];
  bit            exp_ok;
  logic [7:0]    frame[$];

  i_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_w_addr(ram_w_addr), .ram_din(ram_din), .ram_w_en(ram_w_en),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write/done monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (ram_w_en) begin
      got_addr.push_back(ram_w_addr);
      got_data.push_back(ram_din);
    end
    if (done) done_cnt++;
  end

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  // Called just after a negedge; the strobe is taken by the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i]) send_byte(frame[i], $urandom_range(0, max_gap));
  endtask

  task automatic make_frame(input int len, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    for (int i = 0; i < 2 * len; i++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
      frame.push_back(b);
      s = s + b;
    end
`ifdef I_RAM_LOADER_CHECKSUM_EN
    frame.push_back(corrupt ? (s ^ 8'($urandom_range(1, 255))) : s);
`else
    if (corrupt) s = 8'h00;
`endif
  endtask

  // Reference: parse the frame as a byte stream and decide the outcome.
  task automatic model_frame();
    int len;
    logic [7:0] s;
    s = 8'h00;
    exp_data.delete();
    len = int'(frame[1]) + 256 * int'(frame[2]);
    if (len > DEPTH) begin
      exp_ok = 1'b0;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_data.push_back({frame[4 + 2*i], frame[3 + 2*i]});
      s = s + frame[3 + 2*i] + frame[4 + 2*i];
    end
`ifdef I_RAM_LOADER_CHECKSUM_EN
    exp_ok = (frame[3 + 2*len] == s);
`else
    exp_ok = 1'b1;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (ram_w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got=%b exp=0", ram_w_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ram_din !== 16'h0 || ram_w_addr !== '0) begin errors++; $display("FAIL reset_bus got=%h/%h exp=0/0", ram_w_addr, ram_din); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: cpu_rst=%b busy=%b err=%b", cpu_rst, busy, err);
  endtask

  task automatic test_basic_frame();
    ld_en = 1'b1;
    clear_obs();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h12, 1); send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 12'd1 || ram_din !== 16'h5678) begin
      errors++; $display("FAIL basic_latency got en=%b a=%h d=%h exp en=1 a=001 d=5678", ram_w_en, ram_w_addr, ram_din); end
`ifdef I_RAM_LOADER_CHECKSUM_EN
    send_byte(8'h14, 0);
`endif
    repeat (2) @(negedge clk);
    checks++; if (ram_w_en !== 1'b0 || ram_din !== 16'h5678) begin
      errors++; $display("FAIL basic_hold got en=%b d=%h exp en=0 d=5678", ram_w_en, ram_din); end
    checks++; if (got_data.size() !== 2) begin
      errors++; $display("FAIL basic_count got=%0d exp=2", got_data.size()); end
    else begin
      checks++; if (got_addr[0] !== 12'd0 || got_data[0] !== 16'h1234) begin
        errors++; $display("FAIL basic_w0 got=%h:%h exp=000:1234", got_addr[0], got_data[0]); end
      checks++; if (got_addr[1] !== 12'd1 || got_data[1] !== 16'h5678) begin
        errors++; $display("FAIL basic_w1 got=%h:%h exp=001:5678", got_addr[1], got_data[1]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL basic_run got cpu_rst=%b err=%b exp 0/0", cpu_rst, err); end
    $display("basic frame: writes=%0d done=%0d cpu_rst=%b", got_data.size(), done_cnt, cpu_rst);
  endtask

  task automatic test_checksum_and_zero_len();
`ifdef I_RAM_LOADER_CHECKSUM_EN
    clear_obs();
    frame = '{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h00};
    send_frame(2);
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1 || cpu_rst !== 1'b1 || done_cnt !== 0) begin
      errors++; $display("FAIL bad_chk got err=%b cpu_rst=%b done=%0d exp 1/1/0", err, cpu_rst, done_cnt); end
    $display("bad checksum: err=%b cpu_rst=%b done=%0d", err, cpu_rst, done_cnt);
`endif
    clear_obs();
`ifdef I_RAM_LOADER_CHECKSUM_EN
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
`else
    frame = '{8'hA5, 8'h00, 8'h00};
`endif
    send_frame(2);
    repeat (2) @(negedge clk);
    checks++; if (done_cnt !== 1 || cpu_rst !== 1'b0 || err !== 1'b0 || got_data.size() !== 0) begin
      errors++; $display("FAIL zero_len got done=%0d cpu_rst=%b err=%b writes=%0d exp 1/0/0/0",
                         done_cnt, cpu_rst, err, got_data.size()); end
    $display("zero-length frame: done=%0d cpu_rst=%b", done_cnt, cpu_rst);
  endtask

  task automatic test_too_long();
    clear_obs();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL too_long got err=%b cpu_rst=%b busy=%b exp 1/1/0", err, cpu_rst, busy); end
    checks++; if (got_data.size() !== 0) begin
      errors++; $display("FAIL too_long_writes got=%0d exp=0", got_data.size()); end
    $display("len 0x1001: err=%b writes=%0d", err, got_data.size());
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    repeat (TO - 1) @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early got err=%b busy=%b exp 0/1", err, busy); end
    @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_expire got err=%b busy=%b exp 1/0", err, busy); end
    $display("timeout silence: err=%b", err);
    clear_obs();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h22, 0);
    checks++; if (err !== 1'b0 || ram_w_en !== 1'b1 || ram_din !== 16'h2211) begin
      errors++; $display("FAIL timeout_edge got err=%b en=%b d=%h exp 0/1/2211", err, ram_w_en, ram_din); end
`ifdef I_RAM_LOADER_CHECKSUM_EN
    send_byte(8'h33, 0);
`endif
    repeat (2) @(negedge clk);
    checks++; if (cpu_rst !== 1'b0 || done_cnt !== 1) begin
      errors++; $display("FAIL timeout_edge_run got cpu_rst=%b done=%0d exp 0/1", cpu_rst, done_cnt); end
    $display("byte at expiry: err=%b cpu_rst=%b", err, cpu_rst);
  endtask

  task automatic test_run_ld_en();
    ld_en = 1'b0;
    send_byte(8'hA5, 1);
    checks++; if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ld_en_off got cpu_rst=%b busy=%b exp 0/0", cpu_rst, busy); end
    ld_en = 1'b1;
    send_byte(8'hA5, 0);
    checks++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ld_en_on got cpu_rst=%b busy=%b exp 1/1", cpu_rst, busy); end
    $display("run reload: cpu_rst=%b busy=%b", cpu_rst, busy);
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || ram_w_en !== 1'b0) begin
      errors++; $display("FAIL reset_mid got cpu_rst=%b busy=%b err=%b en=%b exp 1/0/0/0", cpu_rst, busy, err, ram_w_en); end
    $display("reset mid-frame: cpu_rst=%b busy=%b", cpu_rst, busy);
  endtask

  task automatic test_random_frames();
    int len;
    bit bad;
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 24);
      bad = ($urandom_range(0, 3) == 0);
      make_frame(len, bad);
      model_frame();
      clear_obs();
      send_frame(3);
      repeat (3) @(negedge clk);
      checks++; if (got_data.size() !== exp_data.size()) begin
        errors++; $display("FAIL rand_count frame %0d got=%0d exp=%0d", f, got_data.size(), exp_data.size()); end
      else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++; if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL rand_write frame %0d idx %0d got=%h:%h exp=%h:%h", f, i, got_addr[i], got_data[i], AW'(i), exp_data[i]); end
        end
      end
      checks++; if (done_cnt !== (exp_ok ? 1 : 0) || err !== !exp_ok || cpu_rst !== !exp_ok) begin
        errors++; $display("FAIL rand_status frame %0d got done=%0d err=%b cpu_rst=%b exp_ok=%b", f, done_cnt, err, cpu_rst, exp_ok); end
      $display("random frame %0d: len=%0d ok=%b writes=%0d err=%b", f, len, exp_ok, got_data.size(), err);
    end
  endtask

  task automatic test_max_len();
    int bad_cnt;
    bad_cnt = 0;
    make_frame(DEPTH, 1'b0);
    model_frame();
    clear_obs();
    send_frame(0);
    repeat (3) @(negedge clk);
    checks++; if (got_data.size() !== DEPTH) begin
      errors++; $display("FAIL max_count got=%0d exp=%0d", got_data.size(), DEPTH); end
    else begin
      for (int i = 0; i < DEPTH; i++)
        if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) bad_cnt++;
      checks++; if (bad_cnt !== 0) begin
        errors++; $display("FAIL max_words got %0d wrong words exp 0", bad_cnt); end
      checks++; if (got_addr[DEPTH-1] !== AW'(DEPTH - 1)) begin
        errors++; $display("FAIL max_last_addr got=%h exp=%h", got_addr[DEPTH-1], AW'(DEPTH - 1)); end
    end
    checks++; if (done_cnt !== 1 || cpu_rst !== 1'b0) begin
      errors++; $display("FAIL max_done got done=%0d cpu_rst=%b exp 1/0", done_cnt, cpu_rst); end
    $display("max length frame: writes=%0d done=%0d", got_data.size(), done_cnt);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_checksum_and_zero_len();
    test_too_long();
    test_timeout();
    test_run_ld_en();
    test_reset_midframe();
    test_random_frames();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
